mul32_seq: RTL and testbench
============================

# mul32_seq

Iterative 32×32 unsigned shift-add multiplier with a 64-bit product. Accepts one operand pair through a valid/ready handshake and retires one multiplier bit per cycle. Every partial-product add goes through an instance of the team's 64-bit carry-lookahead adder `addition64`, with `carry_in` tied to 0. Its `sum` is the accumulator's next value. The block feeds the adder and consumes its result, and it serves as the multiply unit behind the arithmetic datapath.

## Interface
Parameters: none. Widths are fixed by the 64-bit adder.
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair on `a`/`b` is valid
- `in_ready`  out  1  block can accept operands; equals (state == IDLE) & ~rst
- `a`  in  32  multiplicand, unsigned
- `b`  in  32  multiplier, unsigned
- `out_valid`  out  1  `product` is valid
- `out_ready`  in  1  consumer takes `product`
- `product`  out  64  a × b
- `busy`  out  1  high in RUN or DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- Registers:
  - `mcand` (64 bits)
  - `mplier` (32 bits)
  - `acc` (64 bits)
- **IDLE:** on `in_valid & in_ready` (accept):
  - `mcand` ← zero-extended `a`; `mplier` ← `b`; `acc` ← 0.
  - If `b` == 0, go to DONE. Otherwise go to RUN.
- **RUN**, each cycle:
  - `acc` ← `addition64(acc, mplier[0] ? mcand : 0).sum`
  - `mcand` ← `mcand` << 1
  - `mplier` ← `mplier` >> 1
  - If (`mplier` >> 1) == 0, go to DONE (early termination). Otherwise stay in RUN.
- **DONE:**
  - `out_valid` = 1 and `product` = `acc`, both held stable.
  - On `out_valid & out_ready`, go to IDLE.
- **Width rules:**
  - The adder's `carry_out` is always 0, because the product fits in 64 bits. Verification asserts this.
  - `mcand` never loses set bits, because at most 31 shifts precede the last add.
- Operand inputs are ignored except in the accept cycle. Later changes to `a`/`b` have no effect.
- `in_valid` while `in_ready` = 0 is ignored. It is not queued.
- `out_ready` outside DONE is ignored.
- `a` == 0 with `b` != 0 still runs the full RUN sequence and yields 0.
- **Reset:**
  - Applies in any state and takes priority over a handshake in the same cycle.
  - Next state is IDLE, and all registers are cleared to 0.
  - An operation in flight is discarded; `out_valid` never asserts for it.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `out_valid` = 0, `product` = 0, `busy` = 0
  - `in_ready` = 1, provided `rst` is low in that cycle
- Accept at edge T, with k = index of the highest set bit of `b`, plus 1 (1..32):
  - `b` == 0: `out_valid` from T+1.
  - Otherwise: k RUN cycles, and `out_valid` from T+1+k.
- Worst-case latency is 33 cycles (`b[31]` = 1). Best case is 1 cycle (`b` = 0).
- `product` and `out_valid` are registered, with no combinational path from inputs.
- `in_ready` rises the cycle after the output handshake. There is no same-cycle retire-and-accept, so throughput is at most one operation per (latency + 1) cycles.
- The critical path is one 64-bit carry-lookahead add plus the accumulator mux.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `in_valid` = 1.
  - Required: `out_valid` = 0, `product` = 0, `busy` = 0 throughout.
  - Required: `in_ready` = 1 on the first cycle `rst` is low, and no operation starts.
- **Small operands:** `a` = 3, `b` = 5, accepted at T.
  - Required: `out_valid` rises at T+4 with `product` = 15.
  - Required: `in_ready` = 0 from T+1 until one cycle after the pop.
- **Maximum operands:** `a` = `b` = 0xFFFFFFFF.
  - Required: `out_valid` at T+33 with `product` = 0xFFFFFFFE00000001.
  - Required: adder `carry_out` = 0 in every RUN cycle.
- **Zero and early-termination edges:**
  - `b` = 0, `a` = 0x1234: `out_valid` at T+1, `product` = 0.
  - `a` = 0, `b` = 0x80000000: `out_valid` at T+33, `product` = 0.
  - `a` = 0xDEADBEEF, `b` = 1: `out_valid` at T+2, `product` = 0xDEADBEEF.
- **Backpressure:** `a` = 7, `b` = 9, with `out_ready` held low 10 cycles after `out_valid`, and new operands driven with `in_valid` = 1 meanwhile.
  - Required: `product` stays 63 and the new operands are not accepted.
  - Required: after `out_ready` pulses, `in_ready` = 1 the next cycle, and the next pair gives the correct product.
- **Reset mid-operation:** `a` = 5, `b` = 0xFFFF, `rst` pulsed at T+5.
  - Required: IDLE and all-zero outputs the next cycle, and `out_valid` never asserts for the aborted pair.
  - Required: a following `a` = 6, `b` = 7 yields 42 at T'+4.

Source files
------------

// File: rtl/mul32_seq_if.sv
// Operand/result handshake bundle for the iterative 32x32 multiplier.
// The master drives operands and takes results; the slave is the multiplier.
interface mul32_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul32_seq.sv
// Iterative shift-add 32x32 unsigned multiplier retiring one multiplier bit per cycle.
// Every partial-product accumulation goes through the 64-bit carry-lookahead adder below.

// 64-bit adder: 4-bit lookahead groups, group carries chained with group generate/propagate.
module addition64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        carry_in,
  output logic [63:0] sum,
  output logic        carry_out
);
  localparam int unsigned W  = 64;
  localparam int unsigned GW = 4;
  localparam int unsigned NG = W / GW;

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] c;
  logic         c_top;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic       cg;
    logic       grp_g;
    logic       grp_p;
    logic [3:0] lg;
    logic [3:0] lp;
    c     = '0;
    cg    = carry_in;
    grp_g = 1'b0;
    grp_p = 1'b0;
    lg    = '0;
    lp    = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      lg = g[GW*j +: GW];
      lp = p[GW*j +: GW];
      c[GW*j]     = cg;
      c[GW*j + 1] = lg[0] | (lp[0] & cg);
      c[GW*j + 2] = lg[1] | (lp[1] & lg[0]) | (lp[1] & lp[0] & cg);
      c[GW*j + 3] = lg[2] | (lp[2] & lg[1]) | (lp[2] & lp[1] & lg[0])
                  | (lp[2] & lp[1] & lp[0] & cg);
      grp_g = lg[3] | (lp[3] & lg[2]) | (lp[3] & lp[2] & lg[1])
            | (lp[3] & lp[2] & lp[1] & lg[0]);
      grp_p = &lp;
      cg    = grp_g | (grp_p & cg);
    end
    c_top = cg;
  end

  assign sum       = p ^ c;
  assign carry_out = c_top;
endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        rst,
  mul32_seq_if.slave  bus
);
  localparam int unsigned OPW  = 32;
  localparam int unsigned PRDW = 64;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [PRDW-1:0] mcand;
  logic [PRDW-1:0] mcand_nx;
  logic [OPW-1:0]  mplier;
  logic [OPW-1:0]  mplier_nx;
  logic [PRDW-1:0] acc;
  logic [PRDW-1:0] acc_nx;
  logic [PRDW-1:0] addend;
  logic [PRDW-1:0] add_sum;
  logic            add_co;
  logic            accept;

  assign addend = mplier[0] ? mcand : '0;

  addition64 u_add (
    .a         (acc),
    .b         (addend),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = (state == DONE);
  assign bus.product   = acc;
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.in_valid & bus.in_ready;

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state  <= state_nx;
      mcand  <= mcand_nx;
      mplier <= mplier_nx;
      acc    <= acc_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    acc_nx    = acc;
    case (state)
      IDLE: begin
        if (accept) begin
          mcand_nx  = PRDW'(bus.a);
          mplier_nx = bus.b;
          acc_nx    = '0;
          state_nx  = (bus.b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_nx    = add_sum;
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        // Stop as soon as no set multiplier bits remain.
        if (mplier[OPW-1:1] == '0) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The full product always fits in 64 bits, so the adder never carries out.
  a_no_carry: assert property (@(posedge clk) disable iff (rst) (state == RUN) |-> !add_co);
endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: directed edge cases plus random operands
// compared against plain 64-bit multiplication and a highest-set-bit latency rule.
module tb_mul32_seq;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul32_seq_if bus ();

  mul32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int exp_latency(input logic [31:0] b);
    int k = 0;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return (b == 32'd0) ? 1 : 1 + k;
  endfunction

  // Accept one pair, measure latency, hold result for `hold` cycles under junk input, then pop.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string name);
    logic [63:0] expp;
    int          el;
    int          lat;
    bit          seen;
    expp = 64'(a) * 64'(b);
    el   = exp_latency(b);
    seen = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: in_ready=%b want 1", name, bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!seen && lat <= 40) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      else begin
        checks++;
        if (bus.in_ready !== 1'b0 || dut.add_co !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s run_cycle%0d: in_ready=%b busy=%b carry_out=%b want 0/1/0",
                   name, lat, bus.in_ready, bus.busy, dut.add_co);
        end
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: out_valid never rose, want latency %0d", name, el);
    end else begin
      if (lat != el) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, el);
      end
      checks++;
      if (bus.product !== expp || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s product: got %h ready=%b busy=%b want %h ready=0 busy=1",
                 name, bus.product, bus.in_ready, bus.busy, expp);
      end
    end
    repeat (hold) begin
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.product !== expp || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: out_valid=%b product=%h in_ready=%b want 1 %h 0",
                 name, bus.out_valid, bus.product, bus.in_ready, expp);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pop: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               name, bus.out_valid, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.product !== 64'd0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b product=%h busy=%b in_ready=%b want 0 0 0 0",
                 bus.out_valid, bus.product, bus.busy, bus.in_ready);
      end
    end
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_no_start: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_small();
    run_op(32'd3, 32'd5, 0, "small");
  endtask

  task automatic test_max();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "max");
  endtask

  task automatic test_edges();
    run_op(32'h1234, 32'd0, 0, "b_zero");
    run_op(32'd0, 32'h8000_0000, 0, "a_zero");
    run_op(32'hDEAD_BEEF, 32'd1, 0, "b_one");
  endtask

  task automatic test_backpressure();
    run_op(32'd7, 32'd9, 10, "backpressure");
    run_op(32'd11, 32'd13, 0, "after_bp");
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 32'd5; bus.b = 32'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.product !== 64'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: out_valid=%b product=%h busy=%b want 0 0 0",
               bus.out_valid, bus.product, bus.busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready: in_ready=%b want 1", bus.in_ready);
    end
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL midreset_abort: aborted op resumed (saw out_valid/busy=1, want 0)");
    end
    run_op(32'd6, 32'd7, 0, "after_midreset");
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(ra, rb, int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'd3;
    bus.b         = 32'd5;
    bus.out_ready = 1'b0;
    test_reset();
    test_small();
    test_max();
    test_edges();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
